imem_access_arbiter: RTL and testbench
======================================

Name: imem_access_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the core fetch stage and a debug/program loader port.
- Fixed fetch priority while running, with a starvation counter that guarantees the loader a slot.
- A halt FSM drains fetch traffic and gives the loader exclusive access for reprogramming.
- Sits between the fetch stage and the instruction memory. The memory has synchronous read with 1-cycle latency.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width.
- INST_WIDTH, 32, instruction word width.
- MAX_WAIT, 4, maximum consecutive cycles a pending loader request may be denied while running (≥1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_f_req  in  1  fetch read request.
- i_f_addr  in  ADDR_WIDTH  fetch address.
- o_f_gnt  out  1  fetch request accepted this cycle.
- o_f_rvalid  out  1  fetch read data valid.
- o_f_rdata  out  INST_WIDTH  fetch read data.
- i_l_req  in  1  loader request.
- i_l_we  in  1  loader write (1) / read (0).
- i_l_addr  in  ADDR_WIDTH  loader address.
- i_l_wdata  in  INST_WIDTH  loader write data.
- o_l_gnt  out  1  loader request accepted this cycle.
- o_l_rvalid  out  1  loader read data valid.
- o_l_rdata  out  INST_WIDTH  loader read data.
- i_halt_req  in  1  request exclusive loader mode.
- o_halted  out  1  exclusive loader mode active.
- o_mem_en  out  1  memory access enable.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_wdata  out  INST_WIDTH  memory write data.
- i_mem_rdata  in  INST_WIDTH  memory read data, valid the cycle after an enabled read.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - FSM=RUN, starvation counter=0.
  - o_f_rvalid=0, o_l_rvalid=0, o_halted=0.
  - o_f_rdata and o_l_rdata = 0.
  - Combinational outputs follow from the reset state; with no requests, o_mem_en=0 and o_mem_we=0.
- Reset mid-transaction: in-flight reads are discarded and no rvalid is issued afterward.
- Grant is combinational in the request cycle. At most one grant per cycle.
- The memory bus is driven from the granted requester. When nothing is granted: o_mem_en=0, o_mem_we=0, address and wdata = 0.
- Read issued in cycle N: the requester's rvalid is asserted in cycle N+1 and rdata = i_mem_rdata, registered into the output on the N+1 edge.
  - rdata holds its last value when rvalid=0.
- Loader write granted in cycle N: o_mem_we=1 in cycle N. No rvalid is generated.
- Requesters hold address and data stable until granted. There is no backpressure on rvalid.
- FSM states:
  - RUN:
    - Fetch wins when both request, unless starvation counter == MAX_WAIT, in which case the loader wins.
    - Counter increments each cycle i_l_req=1 and the loader is not granted.
    - Counter clears on loader grant or when i_l_req=0.
    - The counter saturates at MAX_WAIT.
    - i_halt_req=1 → DRAIN (transition on next edge).
  - DRAIN:
    - No fetch grants.
    - Loader grants are allowed.
    - Moves to HALTED on the first cycle with no fetch read outstanding, i.e. o_f_rvalid pending=0.
    - Takes at most 1 cycle in DRAIN.
  - HALTED:
    - o_halted=1.
    - o_f_gnt=0; the loader is granted whenever it requests.
    - i_halt_req=0 → RUN, with counter cleared.
  - DRAIN with i_halt_req dropped → RUN.
- Simultaneous halt request and a starved loader in RUN: loader arbitration applies in that cycle; the FSM transition happens at the edge.
- Address wrap: none. Addresses are passed through at full ADDR_WIDTH.

Optional Feature:
- Macro IMEM_WR_PROTECT_EN.
- Defined:
  - Loader writes are granted only in HALTED.
  - A loader write request in RUN/DRAIN is never granted and stalls until HALTED.
  - Loader reads are unaffected.
  - The write does not count toward starvation; the counter holds at 0 while the pending request is a write.
- Undefined: loader writes are arbitrated like reads in all states.

Test Plan:
- Reset then i_f_req=1, i_f_addr=0x10, memory word 0x00500093 → o_f_gnt=1 in the same cycle; next cycle o_f_rvalid=1, o_f_rdata=0x00500093.
- Fetch requests every cycle, loader read at addr 0x20, MAX_WAIT=4 → loader denied 4 cycles, granted on the 5th; o_l_rvalid the following cycle; fetch granted again after.
- i_halt_req=1 with a fetch read in flight → that fetch rvalid is still delivered; o_halted=1 within 2 cycles; no o_f_gnt while halted.
- Halted, loader writes 0xDEADBEEF to 0x05 then reads 0x05 → o_mem_we=1 for one cycle; read returns o_l_rdata=0xDEADBEEF.
- With IMEM_WR_PROTECT_EN, loader write in RUN → o_l_gnt=0 until halted, then granted in the first HALTED cycle.
- Assert i_rst_n=0 the cycle after a loader read grant → o_l_rvalid stays 0; all outputs at reset values.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// Arbitrates the single-port instruction memory between the fetch stage and the loader port.
// Optional build macro IMEM_WR_PROTECT_EN: loader writes are granted only while HALTED.
module imem_access_arbiter #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned INST_WIDTH = 32,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_f_req,
   input  logic [ADDR_WIDTH-1:0] i_f_addr,
   output logic                  o_f_gnt,
   output logic                  o_f_rvalid,
   output logic [INST_WIDTH-1:0] o_f_rdata,
   input  logic                  i_l_req,
   input  logic                  i_l_we,
   input  logic [ADDR_WIDTH-1:0] i_l_addr,
   input  logic [INST_WIDTH-1:0] i_l_wdata,
   output logic                  o_l_gnt,
   output logic                  o_l_rvalid,
   output logic [INST_WIDTH-1:0] o_l_rdata,
   input  logic                  i_halt_req,
   output logic                  o_halted,
   output logic                  o_mem_en,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [INST_WIDTH-1:0] o_mem_wdata,
   input  logic [INST_WIDTH-1:0] i_mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_wait_cnt;
   logic [CNT_W-1:0]      w_wait_nxt;
   logic                  r_f_pend;
   logic                  r_l_pend;
   logic [INST_WIDTH-1:0] r_f_rdata;
   logic [INST_WIDTH-1:0] r_l_rdata;
   logic                  r_halted;
   logic                  w_f_gnt;
   logic                  w_l_gnt;
   logic                  w_l_elig;
   logic                  w_l_cnt_req;
   logic                  w_starved;

`ifdef IMEM_WR_PROTECT_EN
   // Writes wait for HALTED and never accumulate starvation credit.
   assign w_l_elig    = i_l_req && (!i_l_we || (r_state == ST_HALTED));
   assign w_l_cnt_req = i_l_req && !i_l_we;
`else
   assign w_l_elig    = i_l_req;
   assign w_l_cnt_req = i_l_req;
`endif

   assign w_starved = (r_wait_cnt == CNT_W'(MAX_WAIT));

   // Next-state, grant and starvation-counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_f_gnt     = 1'b0;
      w_l_gnt     = 1'b0;
      w_wait_nxt  = '0;
      case (r_state)
         ST_RUN: begin
            if (i_f_req && !(w_l_elig && w_starved)) begin
               w_f_gnt = 1'b1;
            end else begin
               w_l_gnt = w_l_elig;
            end
            if (i_halt_req) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // No fetch is granted here, so the only possible in-flight fetch
            // (issued in the last RUN cycle) completes during this cycle.
            w_l_gnt = w_l_elig;
            if (!i_halt_req) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_HALTED;
            end
         end
         ST_HALTED: begin
            w_l_gnt = w_l_elig;
            if (!i_halt_req) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
      if (w_l_cnt_req && !w_l_gnt) begin
         w_wait_nxt = w_starved ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
         r_halted   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_halted   <= (w_state_nxt == ST_HALTED);
      end
   end

   // Read-return tracking; rdata registers keep the last delivered word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_f_pend  <= 1'b0;
         r_l_pend  <= 1'b0;
         r_f_rdata <= '0;
         r_l_rdata <= '0;
      end else begin
         r_f_pend <= w_f_gnt;
         r_l_pend <= w_l_gnt && !i_l_we;
         if (r_f_pend) begin
            r_f_rdata <= i_mem_rdata;
         end
         if (r_l_pend) begin
            r_l_rdata <= i_mem_rdata;
         end
      end
   end

   assign o_f_gnt    = w_f_gnt;
   assign o_l_gnt    = w_l_gnt;
   assign o_halted   = r_halted;
   assign o_f_rvalid = r_f_pend;
   assign o_l_rvalid = r_l_pend;
   // Memory data arrives in the return cycle; pass it through while valid.
   assign o_f_rdata  = r_f_pend ? i_mem_rdata : r_f_rdata;
   assign o_l_rdata  = r_l_pend ? i_mem_rdata : r_l_rdata;

   assign o_mem_en    = w_f_gnt || w_l_gnt;
   assign o_mem_we    = w_l_gnt && i_l_we;
   assign o_mem_addr  = w_f_gnt ? i_f_addr : (w_l_gnt ? i_l_addr : '0);
   assign o_mem_wdata = w_l_gnt ? i_l_wdata : '0;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Scoreboard bench for imem_access_arbiter with a behavioural synchronous-read memory.
module tb_imem_access_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_f_req;
   logic [7:0]  i_f_addr;
   logic        o_f_gnt;
   logic        o_f_rvalid;
   logic [31:0] o_f_rdata;
   logic        i_l_req;
   logic        i_l_we;
   logic [7:0]  i_l_addr;
   logic [31:0] i_l_wdata;
   logic        o_l_gnt;
   logic        o_l_rvalid;
   logic [31:0] o_l_rdata;
   logic        i_halt_req;
   logic        o_halted;
   logic        o_mem_en;
   logic        o_mem_we;
   logic [7:0]  o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata;

   imem_access_arbiter #(.ADDR_WIDTH(8), .INST_WIDTH(32), .MAX_WAIT(4)) u_dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_f_req(i_f_req), .i_f_addr(i_f_addr), .o_f_gnt(o_f_gnt),
      .o_f_rvalid(o_f_rvalid), .o_f_rdata(o_f_rdata),
      .i_l_req(i_l_req), .i_l_we(i_l_we), .i_l_addr(i_l_addr), .i_l_wdata(i_l_wdata),
      .o_l_gnt(o_l_gnt), .o_l_rvalid(o_l_rvalid), .o_l_rdata(o_l_rdata),
      .i_halt_req(i_halt_req), .o_halted(o_halted),
      .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   always @(posedge i_clk) begin
      if (o_mem_en) begin
         if (o_mem_we) begin
            mem[o_mem_addr] <= o_mem_wdata;
         end else begin
            i_mem_rdata <= mem[o_mem_addr];
         end
      end
   end

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } rd_t;

   rd_t         fq[$];
   rd_t         lq[$];
   int          cyc;
   int          n_vec;
   int          n_err;
   logic [31:0] last_f;
   logic [31:0] last_l;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic chk_reset();
      chk("rst_f_gnt",    32'(o_f_gnt), 32'd0);
      chk("rst_l_gnt",    32'(o_l_gnt), 32'd0);
      chk("rst_f_rvalid", 32'(o_f_rvalid), 32'd0);
      chk("rst_l_rvalid", 32'(o_l_rvalid), 32'd0);
      chk("rst_halted",   32'(o_halted), 32'd0);
      chk("rst_f_rdata",  o_f_rdata, 32'd0);
      chk("rst_l_rdata",  o_l_rdata, 32'd0);
      chk("rst_mem_en",   32'(o_mem_en), 32'd0);
      chk("rst_mem_we",   32'(o_mem_we), 32'd0);
      chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
      chk("rst_mem_wdata", o_mem_wdata, 32'd0);
   endtask

   // Compare read returns against the scoreboard; also checks rdata hold when idle.
   task automatic check_rd();
      bit exp_fv;
      bit exp_lv;
      exp_fv = (fq.size() > 0) && (fq[0].cyc == cyc);
      exp_lv = (lq.size() > 0) && (lq[0].cyc == cyc);
      chk("f_rvalid", 32'(o_f_rvalid), 32'(exp_fv));
      chk("l_rvalid", 32'(o_l_rvalid), 32'(exp_lv));
      if (exp_fv) begin
         last_f = fq[0].data;
         void'(fq.pop_front());
      end
      if (exp_lv) begin
         last_l = lq[0].data;
         void'(lq.pop_front());
      end
      chk("f_rdata", o_f_rdata, last_f);
      chk("l_rdata", o_l_rdata, last_l);
   endtask

   // One cycle: inputs already driven; check grants/bus/halted at negedge, then advance.
   task automatic step(input bit fg, input bit lg, input bit hl);
      @(negedge i_clk);
      chk("f_gnt",  32'(o_f_gnt), 32'(fg));
      chk("l_gnt",  32'(o_l_gnt), 32'(lg));
      chk("halted", 32'(o_halted), 32'(hl));
      chk("mem_en", 32'(o_mem_en), 32'(fg | lg));
      if (fg) begin
         chk("mem_addr_f", 32'(o_mem_addr), 32'(i_f_addr));
         chk("mem_we_f",   32'(o_mem_we), 32'd0);
         fq.push_back('{cyc + 1, ref_mem[i_f_addr]});
      end else if (lg) begin
         chk("mem_addr_l", 32'(o_mem_addr), 32'(i_l_addr));
         chk("mem_we_l",   32'(o_mem_we), 32'(i_l_we));
         if (i_l_we) begin
            chk("mem_wdata", o_mem_wdata, i_l_wdata);
            ref_mem[i_l_addr] = i_l_wdata;
         end else begin
            lq.push_back('{cyc + 1, ref_mem[i_l_addr]});
         end
      end else begin
         chk("mem_we_idle",   32'(o_mem_we), 32'd0);
         chk("mem_addr_idle", 32'(o_mem_addr), 32'd0);
      end
      check_rd();
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; last_f = '0; last_l = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'hA500_0000 | (32'(i) * 32'h0001_0101);
         ref_mem[i] = 32'hA500_0000 | (32'(i) * 32'h0001_0101);
      end
      mem[16] = 32'h0050_0093; ref_mem[16] = 32'h0050_0093;
      i_rst_n = 1'b0; i_f_req = 1'b0; i_f_addr = '0; i_l_req = 1'b0; i_l_we = 1'b0;
      i_l_addr = '0; i_l_wdata = '0; i_halt_req = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk_reset();
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      // First fetch: same-cycle grant, data next cycle
      i_f_req = 1'b1; i_f_addr = 8'h10;
      step(1, 0, 0);
      i_f_req = 1'b0;
      step(0, 0, 0);

      // Starvation: loader denied MAX_WAIT cycles then wins
      i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = 8'h20; i_f_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         i_f_addr = 8'(8'h30 + i);
         step(1, 0, 0);
      end
      step(0, 1, 0);
      i_l_req = 1'b0; i_f_addr = 8'h34;
      step(1, 0, 0);
      i_f_req = 1'b0;
      step(0, 0, 0);

      // Loader alone is granted immediately
      i_l_req = 1'b1; i_l_addr = 8'h33;
      step(0, 1, 0);
      i_l_req = 1'b0;
      step(0, 0, 0);

      // Halt with a fetch in flight
      i_f_req = 1'b1; i_f_addr = 8'h40; i_halt_req = 1'b1;
      step(1, 0, 0);
      i_f_addr = 8'h41;
      step(0, 0, 0);
      step(0, 0, 1);
      i_f_req = 1'b0;

      // Halted reprogramming: write then read back
      i_l_req = 1'b1; i_l_we = 1'b1; i_l_addr = 8'h05; i_l_wdata = 32'hDEAD_BEEF;
      step(0, 1, 1);
      i_l_we = 1'b0;
      step(0, 1, 1);
      i_l_req = 1'b0; i_f_req = 1'b1; i_f_addr = 8'h11;
      step(0, 0, 1);

      // Release halt; fetch resumes once back in RUN
      i_halt_req = 1'b0;
      step(0, 0, 1);
      step(1, 0, 0);
      i_f_req = 1'b0;

      // Halt dropped during DRAIN returns to RUN
      i_halt_req = 1'b1;
      step(0, 0, 0);
      i_halt_req = 1'b0;
      step(0, 0, 0);
      i_f_req = 1'b1; i_f_addr = 8'h12;
      step(1, 0, 0);

      // Starved loader and halt in the same cycle
      i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = 8'h21;
      for (int i = 0; i < 4; i++) begin
         i_f_addr = 8'(8'h50 + i);
         step(1, 0, 0);
      end
      i_halt_req = 1'b1;
      step(0, 1, 0);
      i_l_addr = 8'h22;
      step(0, 1, 0);
      i_l_req = 1'b0; i_f_req = 1'b0;
      step(0, 0, 1);

      // Reset right after a loader read grant discards the read
      i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = 8'h05;
      @(negedge i_clk);
      chk("pre_rst_l_gnt", 32'(o_l_gnt), 32'd1);
      i_rst_n = 1'b0; i_l_req = 1'b0; i_halt_req = 1'b0;
      #1;
      chk_reset();
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk_reset();
      i_rst_n = 1'b1;
      fq.delete(); lq.delete(); last_f = '0; last_l = '0;
      @(posedge i_clk); #1;
      cyc++;
      step(0, 0, 0);

`ifdef IMEM_WR_PROTECT_EN
      // Loader write stalls in RUN/DRAIN, granted on first HALTED cycle
      i_l_req = 1'b1; i_l_we = 1'b1; i_l_addr = 8'h06; i_l_wdata = 32'h1234_5678;
      step(0, 0, 0);
      i_f_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         i_f_addr = 8'(8'h60 + i);
         step(1, 0, 0);
      end
      i_f_req = 1'b0; i_halt_req = 1'b1;
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 1, 1);
      i_l_req = 1'b0; i_halt_req = 1'b0;
      step(0, 0, 1);
`else
      // Loader write in RUN is arbitrated like a read
      i_l_req = 1'b1; i_l_we = 1'b1; i_l_addr = 8'h06; i_l_wdata = 32'h1234_5678;
      step(0, 1, 0);
`endif
      i_l_we = 1'b0; i_l_req = 1'b1; i_l_addr = 8'h06;
      step(0, 1, 0);
      i_l_req = 1'b0;
      step(0, 0, 0);

      chk("f_queue_empty", 32'(fq.size()), 32'd0);
      chk("l_queue_empty", 32'(lq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
